// File: rtl/piso_pkg.sv
// Framing constants and receiver state type shared by the PISO transmitter and
// the SIPO receiver: four byte slots, each 8 data bits LSB first plus even parity.
package piso_pkg;

    localparam int BYTE_BITS      = 8;
    localparam int NUM_SLOTS      = 4;
    localparam int SLOT_BITS      = BYTE_BITS + 1;
    localparam int FRAME_BITS     = NUM_SLOTS * SLOT_BITS;
    localparam int DATA_BITS      = NUM_SLOTS * BYTE_BITS;
    localparam int PAR_POS        = SLOT_BITS - 1;
    localparam int LAST_BIT       = FRAME_BITS - 1;
    localparam int MAX_RESP_DELAY = 8;
    localparam int RESP_CNT_W     = $clog2(MAX_RESP_DELAY);

    typedef enum logic {
        RECV = 1'b0,
        RESP = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sipo_receiver.sv
// Serial-in/parallel-out frame receiver: checks framing and per-byte parity,
// answers with a delayed ack/nack pulse and presents the word on a valid/ready port.
module sipo_receiver
    import piso_pkg::*;
#(
    parameter int RESP_DELAY = 1,
    parameter int CNT_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 s_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ack_o,
    output logic                 nack_o,
    output logic [DATA_BITS-1:0] p_o,
    output logic                 valid_o,
    input  logic                 rdy_i,
    output logic [CNT_W-1:0]     nack_cnt_o
);

    localparam int BIT_CNT_W = 6;
    localparam logic [BIT_CNT_W-1:0]  SLOT_BITS_C = BIT_CNT_W'(SLOT_BITS);
    localparam logic [BIT_CNT_W-1:0]  LAST_IDX    = BIT_CNT_W'(LAST_BIT);
    localparam logic [3:0]            PAR_POS_C   = 4'(PAR_POS);
    localparam logic [RESP_CNT_W-1:0] RESP_LOAD   = RESP_CNT_W'(RESP_DELAY - 1);

    rx_state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [RESP_CNT_W-1:0]    resp_cnt_q, resp_cnt_d;
    logic [DATA_BITS-1:0]     data_q, data_d;
    logic                     par_acc_q, par_acc_d;
    logic                     par_err_q, par_err_d;
    logic                     frame_err_q, frame_err_d;
    logic                     ack_q, ack_d;
    logic                     nack_q, nack_d;
    logic [DATA_BITS-1:0]     p_q, p_d;
    logic                     valid_q, valid_d;
    logic [CNT_W-1:0]         nack_cnt_q, nack_cnt_d;

    logic [1:0]               slot;
    logic [3:0]               pos;
    logic                     good;

    assign slot = 2'(bit_cnt_q / SLOT_BITS_C);
    assign pos  = 4'(bit_cnt_q % SLOT_BITS_C);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        data_d      = data_q;
        par_acc_d   = par_acc_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        ack_d       = 1'b0;
        nack_d      = 1'b0;
        p_d         = p_q;
        valid_d     = valid_q;
        nack_cnt_d  = nack_cnt_q;
        good        = 1'b0;

        if (valid_q && rdy_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            RECV: begin
                if (valid_i) begin
                    if (!last_i && bit_cnt_q == LAST_IDX) begin
                        // Overlong frame: flag it and discard bits until last_i.
                        frame_err_d = 1'b1;
                    end else begin
                        if (pos == PAR_POS_C) begin
                            if (s_i != par_acc_q) begin
                                par_err_d = 1'b1;
                            end
                            par_acc_d = 1'b0;
                        end else begin
                            data_d[{slot, pos[2:0]}] = s_i;
                            par_acc_d                = par_acc_q ^ s_i;
                        end

                        if (last_i) begin
                            if (bit_cnt_q != LAST_IDX) begin
                                frame_err_d = 1'b1;
                            end
                            bit_cnt_d  = '0;
                            resp_cnt_d = RESP_LOAD;
                            state_d    = RESP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end

            RESP: begin
                if (resp_cnt_q != '0) begin
                    resp_cnt_d = resp_cnt_q - 1'b1;
                end else begin
                    // A word still waiting for the consumer refuses the new frame.
                    good = !par_err_q && !frame_err_q && !(valid_q && !rdy_i);
                    if (good) begin
                        ack_d   = 1'b1;
                        p_d     = data_q;
                        valid_d = 1'b1;
                    end else begin
                        nack_d = 1'b1;
                        if (nack_cnt_q != '1) begin
                            nack_cnt_d = nack_cnt_q + 1'b1;
                        end
                    end
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    par_acc_d   = 1'b0;
                    state_d     = RECV;
                end
            end

            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: the capture register is an ordinary flop bank, so it is reset
        // with the rest; p_o must read zero out of reset.
        if (!reset_n_i) begin
            state_q     <= RECV;
            bit_cnt_q   <= '0;
            resp_cnt_q  <= '0;
            data_q      <= '0;
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ack_q       <= 1'b0;
            nack_q      <= 1'b0;
            p_q         <= '0;
            valid_q     <= 1'b0;
            nack_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            data_q      <= data_d;
            par_acc_q   <= par_acc_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            ack_q       <= ack_d;
            nack_q      <= nack_d;
            p_q         <= p_d;
            valid_q     <= valid_d;
            nack_cnt_q  <= nack_cnt_d;
        end
    end

    assign ack_o      = ack_q;
    assign nack_o     = nack_q;
    assign p_o        = p_q;
    assign valid_o    = valid_q;
    assign nack_cnt_o = nack_cnt_q;

endmodule

// File: doc/sipo_receiver.md
# sipo_receiver

Serial-in/parallel-out receiver that sits directly downstream of the PISO converter. It consumes the 36-bit serial frame: four bytes, each sent LSB first as 8 data bits followed by 1 even-parity bit, with `last` on the final bit. It checks framing and parity, answers the sender with a one-cycle `ack`/`nack` inside the sender's 8-cycle wait window, and presents the recovered 32-bit word on a valid/ready parallel output port.

## Interface
Parameters:
- `RESP_DELAY`, default 1: cycles from the accepted last bit to the ack/nack pulse; legal range 1..8.
- `CNT_W`, default 8: width of the saturating nack counter.

Ports:
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `s_i`  in  1  serial data bit.
- `valid_i`  in  1  `s_i` holds a frame bit this cycle.
- `last_i`  in  1  final bit of the frame; only meaningful with `valid_i`.
- `ack_o`  out  1  one-cycle pulse: frame accepted.
- `nack_o`  out  1  one-cycle pulse: frame rejected; the sender retransmits.
- `p_o`  out  32  recovered word; byte0 = first byte received.
- `valid_o`  out  1  `p_o` holds an unread word.
- `rdy_i`  in  1  consumer takes `p_o` when `valid_o && rdy_i`.
- `nack_cnt_o`  out  CNT_W  saturating count of nacks issued.

## Operation
States:
- **RECV**: collects the frame.
- **RESP**: counts down `RESP_DELAY`, then pulses the response.
- Reset enters RECV.

RECV:
- A bit is taken on each `valid_i` cycle; cycles with `valid_i` low are bubbles and are skipped.
- `bit_cnt` (6b, 0..35) is split into slot = `bit_cnt/9` and pos = `bit_cnt%9`.
- pos 0..7: the bit is shifted into `data[8*slot+pos]` and XORed into `par_acc`.
- pos 8: if `s_i != par_acc`, set `par_err`; then clear `par_acc`.
- `valid_i && last_i`:
  - Set `frame_err` if `bit_cnt != 35`.
  - Go to RESP and clear `bit_cnt`.
- `valid_i && !last_i` at `bit_cnt == 35`:
  - Set `frame_err`.
  - Drop further bits without counting them until `last_i` arrives.

RESP:
- `valid_i` is ignored; no bits are captured.
- After `RESP_DELAY` cycles, evaluate `good = !par_err && !frame_err && !(valid_o && !rdy_i)`.
- Good frame:
  - Pulse `ack_o`, load `p_o <= data`, set `valid_o`.
- Otherwise:
  - Pulse `nack_o` and increment `nack_cnt_o`, saturating at all-ones.
  - `p_o` and `valid_o` are unchanged.
- In both cases clear `par_err`, `frame_err` and `par_acc`, then return to RECV.

Output port:
- `valid_o` clears on `valid_o && rdy_i`.
- If a load and a take happen in the same cycle, the load wins and `valid_o` stays 1 with the new word.

Other rules:
- `ack_o` and `nack_o` are never high together.
- Each frame ending in `last_i` produces exactly one pulse.

## Timing
- Reset values: `ack_o` = 0, `nack_o` = 0, `valid_o` = 0, `p_o` = 0, `nack_cnt_o` = 0; internal `bit_cnt`, `par_acc`, `par_err`, `frame_err` = 0; state = RECV.
- Response latency: the pulse is registered `RESP_DELAY` cycles after the edge that samples `last_i`. With the default of 1, it rises the cycle after `last_i`.
- Parallel latency: `p_o` and `valid_o` update on the same edge that raises `ack_o`.
- Back-to-back frames: a new first bit is accepted on the cycle after the response pulse. Bits arriving earlier (still in RESP) are dropped.
- Reset mid-frame or mid-RESP: everything returns to reset values immediately; no response is emitted for the partial frame.
- `rdy_i` may be held high permanently; the word is then visible for exactly one cycle.

## Structure
- Shared package `piso_pkg` holds:
  - `FRAME_BITS` = 36, `SLOT_BITS` = 9, `DATA_BITS` = 32.
  - The receiver state enum `rx_state_t` {RECV, RESP}.
  - The framing constants shared with the PISO side.
- No sub-module. Parity accumulation, the slot/pos counter and the output register are inline; the whole block is one FSM plus datapath.

## Test plan
- **Good frame:** reset, then a continuous 36-bit frame of word 0xA5C30F11 with correct parity -> `ack_o` high for one cycle after `last_i`; `p_o` = 0xA5C30F11 and `valid_o` = 1 until `rdy_i`.
- **Parity error:** same frame with the byte-2 parity bit (bit 26) inverted -> `nack_o` one cycle, `valid_o` stays 0, `nack_cnt_o` = 1.
- **Short frame:** `last_i` asserted at bit index 20 -> `nack_o`. A following correct frame of 0x12345678 -> `ack_o`, `p_o` = 0x12345678.
- **Output full:** hold `rdy_i` = 0 and send two good frames (0x1, then 0x2) -> first `ack_o` with `p_o` = 0x1, second `nack_o` with `p_o` still 0x1. Raise `rdy_i` and resend 0x2 -> `ack_o`, `p_o` = 0x2.
- **Reset mid-frame:** assert `reset_n_i` = 0 at bit 17, asynchronously -> all outputs 0 immediately and no pulse. Then a full frame of 0xDEADBEEF -> `ack_o`, `p_o` = 0xDEADBEEF.
- **Bubbles:** `valid_i` toggled every other cycle across the whole 0xCAFEF00D frame -> `ack_o`, `p_o` = 0xCAFEF00D. Repeat with 300 forced nacks -> `nack_cnt_o` saturates at 255.
